// File: rtl/ram_master.sv
// ram_master: bus initiator for the 4-bit data RAM.
//
// Takes one memory request at a time from the CPU datapath and runs the RAM
// bus cycles for it. READ and WRITE map to a single RAM access. ADDM and NORM
// are read-modify-write: they read the old value, combine it with the operand,
// and write the result back. The datapath still sees one request and one
// response.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_op               00 READ, 01 WRITE, 10 ADDM, 11 NORM
//   req_addr, req_wdata  target address; write data or RMW operand
//   rsp_valid            one-cycle response pulse
//   rsp_rdata/carry/zero response fields, held after the pulse
//   address, data        RAM address and shared tri-state data bus
//   csRAM, weRAM         RAM chip select and write enable (1 = write)
//   dbg_state            current FSM state (IDLE=0, RD_ADDR=1, RD_DATA=2,
//                        WR=3, RESP=4)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE. Requests offered in any
// other state are ignored and not queued. Responses have no backpressure:
// rsp_* are valid only during the single cycle in which rsp_valid is 1.
//
// Every output except data comes straight from a flop. The *_d values are
// computed from the next state, so each output is already correct in the
// first cycle of the state it belongs to.
module ram_master #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  csRAM,
  output logic                  weRAM,
  output logic [2:0]            dbg_state
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADDM  = 2'b10;
  localparam logic [1:0] OP_NORM  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] wr_q, wr_d;        // value to write / result
  logic                  carry_q, carry_d;  // pending ADDM carry
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  req_ready_q, req_ready_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_carry_q, rsp_carry_d;
  logic                  rsp_zero_q, rsp_zero_d;

  logic                  accept;
  logic [DATA_WIDTH:0]   sum;

  // Ready is checked through its own flop as well as the state. This keeps
  // the block from accepting on the first edge after reset release, because
  // req_ready is still 0 in that cycle.
  assign accept = (state_q == S_IDLE) && req_valid && req_ready_q;

  // Process 1: state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      wdata_q     <= '0;
      wr_q        <= '0;
      carry_q     <= 1'b0;
      address_q   <= '0;
      req_ready_q <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      carry_q     <= carry_d;
      address_q   <= address_d;
      req_ready_q <= req_ready_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  // Process 2: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (req_op == OP_WRITE) ? S_WR : S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: state_d = (op_q == OP_READ) ? S_RESP : S_WR;
      S_WR:      state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Process 3: output and datapath logic
  always_comb begin
    op_d        = op_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    carry_d     = carry_q;
    address_d   = address_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    sum         = {1'b0, data} + {1'b0, wdata_q};

    // The address changes only on acceptance, which happens while csRAM is 0.
    // It therefore stays stable for the whole chip-select window.
    if (accept) begin
      op_d      = req_op;
      wdata_d   = req_wdata;
      address_d = req_addr;
      wr_d      = req_wdata;
      carry_d   = 1'b0;
    end

    // The RAM drives data during RD_DATA. The read value is combined here and
    // registered at the end of the cycle, so WR drives a settled result.
    if (state_q == S_RD_DATA) begin
      carry_d = 1'b0;
      case (op_q)
        OP_ADDM: begin
          wr_d    = sum[DATA_WIDTH-1:0];
          carry_d = sum[DATA_WIDTH];
        end
        OP_NORM: wr_d = ~(data | wdata_q);
        default: wr_d = data;
      endcase
    end

    // Response fields update only when entering RESP, so they hold afterwards.
    if (state_d == S_RESP) begin
      rsp_rdata_d = wr_d;
      rsp_carry_d = carry_d;
      rsp_zero_d  = (wr_d == '0);
    end

    req_ready_d = (state_d == S_IDLE);
    cs_d        = (state_d == S_RD_ADDR) || (state_d == S_RD_DATA) ||
                  (state_d == S_WR);
    we_d        = (state_d == S_WR);
    rsp_valid_d = (state_d == S_RESP);
  end

  // The master drives the bus only in WR. Reset returns the state to IDLE at
  // once, which releases the bus immediately.
  assign data      = (state_q == S_WR) ? wr_q : {DATA_WIDTH{1'bz}};

  assign req_ready = req_ready_q;
  assign csRAM     = cs_q;
  assign weRAM     = we_q;
  assign address   = address_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_master.sv
// Testbench for ram_master. Contains a registered-read RAM model on the
// shared bus, a behavioural reference (memory array + expected queue) and a
// per-cycle compare process.
module tb_ram_master;
  localparam int DW = 4;
  localparam int AW = 12;
  localparam int W  = 6;  // {zero, carry, rdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_carry;
  logic          rsp_zero;
  logic [AW-1:0] address;
  wire  [DW-1:0] data;
  logic          csRAM;
  logic          weRAM;
  logic [2:0]    dbg_state;

  ram_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .address(address), .data(data),
    .csRAM(csRAM), .weRAM(weRAM), .dbg_state(dbg_state)
  );

  // ---------------- RAM model (registered read, one-cycle latency) ----------------
  logic [DW-1:0] ram_mem [0:4095];
  logic [DW-1:0] ram_out = '0;
  logic          ram_drive = 1'b0;
  int            cyc = 0;

  assign data = (ram_drive && csRAM && !weRAM) ? ram_out : {DW{1'bz}};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csRAM && weRAM) ram_mem[address] <= data;
    if (csRAM && !weRAM) ram_out <= ram_mem[address];
    ram_drive <= csRAM && !weRAM;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] model_mem [0:4095];
  logic [W-1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            chk_en = 1'b0;
  bit            active = 1'b0;
  int            cur_acc = 0;   // cyc value in the cycle after the accept edge
  int            cur_lat = 0;   // response cycle number for the op (accept edge = 0)
  logic [1:0]    cur_op = 2'b00;
  logic [AW-1:0] cur_addr = '0;
  logic [W-1:0]  last_rsp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle outside reset, the bus and response outputs
  // must match the cycle windows implied by the op latency.
  always @(negedge clk) begin
    int s;
    bit in_win;
    logic [W-1:0] e;
    if (chk_en) begin
      s = cyc - cur_acc + 1;
      in_win = active && (s >= 1) && (s < cur_lat);
      chk("csRAM", {31'd0, csRAM}, {31'd0, in_win});
      chk("weRAM", {31'd0, weRAM},
          {31'd0, in_win && (s == cur_lat - 1) && (cur_op != 2'b00)});
      if (in_win) chk("address", {20'd0, address}, {20'd0, cur_addr});
      chk("req_ready", {31'd0, req_ready},
          {31'd0, !(active && (s >= 1) && (s <= cur_lat))});
      if (active && (s == cur_lat)) begin
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("exp_q_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          last_rsp = e;
          chk("rsp_fields", {26'd0, rsp_zero, rsp_carry, rsp_rdata}, {26'd0, e});
        end
      end else begin
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rsp_hold", {26'd0, rsp_zero, rsp_carry, rsp_rdata}, {26'd0, last_rsp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // While the block is busy, keep req_valid high with random fields; these
  // requests must be ignored.
  task automatic junk();
    req_valid = 1'b1;
    req_op    = 2'($urandom_range(0, 3));
    req_addr  = AW'($urandom_range(0, 4095));
    req_wdata = DW'($urandom_range(0, 15));
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready) begin
      junk();
      n++;
      if (n > 30) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ready_timeout: req_ready still 0 after %0d cycles, expected 1", n);
        finish_run();
      end
      @(negedge clk);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output logic [W-1:0] res);
    logic [DW:0]   sum;
    logic [DW-1:0] m;
    logic [DW-1:0] r;
    logic          c;
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    m = model_mem[addr];
    c = 1'b0;
    case (op)
      2'b00: r = m;
      2'b01: r = wd;
      2'b10: begin sum = {1'b0, m} + {1'b0, wd}; r = sum[DW-1:0]; c = sum[DW]; end
      default: r = ~(m | wd);
    endcase
    if (op != 2'b00) model_mem[addr] = r;
    res = {(r == '0), c, r};
    @(posedge clk);
    #1;
    cur_acc  = cyc;
    cur_lat  = (op == 2'b00) ? 3 : (op == 2'b01) ? 2 : 4;
    cur_op   = op;
    cur_addr = addr;
    active   = 1'b1;
    exp_q.push_back(res);
    junk();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (req_ready) req_valid = 1'b0;
      else junk();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    active = 1'b0;
    exp_q.delete();
    last_rsp = '0;
    chk_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] res;
    logic [1:0]   op;
    logic [AW-1:0] a;
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i]   = '0;
      model_mem[i] = '0;
    end
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;

    // Reset values while reset is asserted
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_cs", {31'd0, csRAM}, 32'd0);
    chk("rst_we", {31'd0, weRAM}, 32'd0);
    chk("rst_address", {20'd0, address}, 32'd0);
    chk("rst_rsp", {26'd0, rsp_valid, rsp_zero, rsp_carry, rsp_rdata}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    release_reset();

    // WRITE then READ at 0x123
    do_req(2'b01, 12'h123, 4'hA, res); chk("pin_wr123", {26'd0, res}, 32'h0A);
    do_req(2'b00, 12'h123, 4'h0, res); chk("pin_rd123", {26'd0, res}, 32'h0A);

    // ADDM with carry
    do_req(2'b01, 12'h045, 4'hF, res);
    do_req(2'b10, 12'h045, 4'h2, res); chk("pin_addm", {26'd0, res}, 32'h11);
    do_req(2'b00, 12'h045, 4'h0, res); chk("pin_rd045", {26'd0, res}, 32'h01);

    // NORM, then NORM producing zero
    do_req(2'b01, 12'h7FF, 4'h5, res);
    do_req(2'b11, 12'h7FF, 4'h8, res); chk("pin_norm1", {26'd0, res}, 32'h02);
    do_req(2'b11, 12'h7FF, 4'hF, res); chk("pin_norm2", {26'd0, res}, 32'h20);

    // Address extremes
    do_req(2'b01, 12'hFFF, 4'h6, res);
    do_req(2'b01, 12'h000, 4'hC, res);
    do_req(2'b00, 12'hFFF, 4'h0, res); chk("pin_rdfff", {26'd0, res}, 32'h06);
    do_req(2'b00, 12'h000, 4'h0, res); chk("pin_rd000", {26'd0, res}, 32'h0C);

    // Back-to-back alternating READ/WRITE with req_valid held high
    for (int i = 0; i < 8; i++) begin
      do_req((i % 2 == 0) ? 2'b00 : 2'b01, AW'(12'h200 + i), DW'(i), res);
    end

    // Reset during WR of WRITE 0x010 <- 0x3 (memory holds 0x9)
    do_req(2'b01, 12'h010, 4'h9, res);
    wait_ready();
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 12'h010;
    req_wdata = 4'h3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk_en = 1'b0;
    chk("wr_cs_before_rst", {31'd0, csRAM}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cs", {31'd0, csRAM}, 32'd0);
    chk("rst_mid_we", {31'd0, weRAM}, 32'd0);
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rst_mid_valid2", {31'd0, rsp_valid}, 32'd0);
    release_reset();
    do_req(2'b00, 12'h010, 4'h0, res); chk("pin_rd010", {26'd0, res}, 32'h09);

    // Randomized traffic concentrated on a few addresses so RMW ops hit data
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 12'h000;
        1: a = 12'hFFF;
        2: a = AW'($urandom_range(0, 4095));
        default: a = AW'($urandom_range(0, 7));
      endcase
      do_req(op, a, DW'($urandom_range(0, 15)), res);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(8);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    finish_run();
  end

endmodule

// File: doc/ram_master.md
# ram_master

Bus initiator for the 4-bit data RAM: it accepts single-nibble memory requests from the CPU datapath and sequences `csRAM`/`weRAM`/`address`/`data` to the RAM. It covers the RAM's registered one-cycle read latency and the shared tri-state data bus. It also executes the read-modify-write memory ops (ADDM, NORM) so the datapath sees one request and one response per instruction. It sits between the CPU control unit and the RAM.

## Interface
Parameters:
- `DATA_WIDTH`, 4: nibble width of RAM data.
- `ADDR_WIDTH`, 12: RAM address width.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  block can accept a request.
- `req_op`  input  2  operation: 00 READ, 01 WRITE, 10 ADDM, 11 NORM.
- `req_addr`  input  ADDR_WIDTH  target address.
- `req_wdata`  input  DATA_WIDTH  write data (WRITE) or operand (ADDM/NORM).
- `rsp_valid`  output  1  one-cycle pulse: response fields valid.
- `rsp_rdata`  output  DATA_WIDTH  READ: memory value; WRITE: written value; ADDM/NORM: value written back.
- `rsp_carry`  output  1  ADDM carry-out; 0 for other ops.
- `rsp_zero`  output  1  `rsp_rdata == 0`.
- `address`  output  ADDR_WIDTH  RAM address.
- `data`  inout  DATA_WIDTH  RAM data bus; driven only in WR state, otherwise high-Z.
- `csRAM`  output  1  RAM chip select.
- `weRAM`  output  1  RAM write enable (1 = write, 0 = read).

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready` at an edge, latch op, addr and wdata.
  - Next state is RD_ADDR for READ/ADDM/NORM, and WR for WRITE.
- RD_ADDR: `csRAM`=1, `weRAM`=0, `address`=latched addr. The RAM registers its output at the end of this cycle. Next state: RD_DATA.
- RD_DATA: `csRAM`=1, `weRAM`=0. The RAM drives `data`; it is sampled into `rd_q` at the end of the cycle. Next state depends on op:
  - READ: next state RESP, result = `rd_q`.
  - ADDM: next state WR; wr value = low 4 bits of the 5-bit sum `rd + wdata`; carry = bit 4.
  - NORM: next state WR; wr value = ~(rd | wdata).
- WR: `csRAM`=1, `weRAM`=1, `data` driven with the wr value. The RAM writes at the end of the cycle. Next state: RESP. Result = wr value.
- RESP: `csRAM`=0; `rsp_valid`=1 with result, carry and zero. Next state: IDLE.
- `req_ready` is 0 in every state except IDLE. Requests presented in other states are ignored and not queued.
- Responses have no backpressure. The consumer must take `rsp_*` in the pulse cycle.
- `rsp_rdata`, `rsp_carry` and `rsp_zero` hold their last value after the pulse.
- `address` stays at the latched value from RD_ADDR through WR. It is never changed while `csRAM`=1.
- Bus ownership: the master drives `data` only when state==WR. In RD_ADDR and RD_DATA it is high-Z, so there is no contention with the RAM.
- Arithmetic is modulo 2^DATA_WIDTH. Addresses are used as given, with no increment or wrap logic in this block.

## Timing
- Accept edge = cycle 0.
- `rsp_valid` is high in the following cycle per op:
  - READ: cycle 3.
  - WRITE: cycle 2.
  - ADDM and NORM: cycle 4.
- `req_ready` returns high the cycle after RESP.
- Back-to-back throughput:
  - READ: one request per 4 cycles.
  - WRITE: one request per 3 cycles.
  - RMW: one request per 5 cycles.
- Reset (`rst_n`=0, asynchronous):
  - State IDLE.
  - `csRAM`=0, `weRAM`=0, `address`=0, `data` high-Z.
  - `req_ready`=0 while asserted; 1 from the first cycle after deassertion.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_carry`=0, `rsp_zero`=0.
- Reset mid-operation: `csRAM` drops immediately and no response is produced.
  - Reset during WR, before the edge, means the write is not performed.
  - For a RMW, memory keeps either the old or the complete new value, never a partial result.
- All outputs except `data` come straight from registers (registered in, registered out).

## Test plan
- WRITE addr 0x123 data 0xA, then READ 0x123 -> WRITE `rsp_valid` at cycle 2 with rdata 0xA; READ `rsp_valid` at cycle 3 with rdata 0xA, zero=0, carry=0.
- Preload 0x045 = 0xF, ADDM operand 0x2 -> rsp rdata 0x1, carry=1 at cycle 4; subsequent READ 0x045 returns 0x1.
- Preload 0x7FF = 0x5, NORM operand 0x8 -> rsp rdata 0x2 (~0xD); a second NORM with operand 0xF gives rdata 0x0, zero=1.
- `req_valid` held high with alternating READ/WRITE -> `req_ready` low in all non-IDLE cycles; no request dropped or duplicated; `csRAM` never high in IDLE or RESP; `data` high-Z whenever `weRAM`=0.
- Address 0xFFF and 0x000 WRITE/READ -> correct values, `address` stable throughout every `csRAM` window.
- `rst_n` pulsed low during WR of a WRITE 0x010 data 0x3 (mem was 0x9) -> `csRAM`=0 immediately, no `rsp_valid`; READ 0x010 after reset returns 0x9.
